filter2d_frame_src: RTL and testbench

//  Raster pixel transmitter that drives the 2D filter input stream: the producer end of the filter's

---
 rtl/filter2d_frame_src.sv | 244 ++++++++++++++++++++++++
 tb/tb_filter2d_frame_src.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter2d_frame_src.sv
`default_nettype none
//==============================================================================
// Module   : filter2d_frame_src
// Purpose  : Raster test-pattern source feeding the 2D filter pixel stream,
//            with SOF/EOL/EOF markers and programmable H/V blanking.
//            Define FILTER2D_SRC_CONT_EN for back-to-back frames.
// Revision : 1.0  initial release
//==============================================================================

module filter2d_frame_src #(
    parameter int FRAME_W    = 1920,
    parameter int FRAME_H    = 1080,
    parameter int DOUT_WIDTH = 8,
    parameter int HBLANK     = 16,
    parameter int VBLANK     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DOUT_WIDTH-1:0] m_data_o,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  m_eof_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int c_xw   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int c_yw   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int c_bmax = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int c_bw   = (c_bmax > 1) ? $clog2(c_bmax) : 1;
    localparam int c_pw0  = (DOUT_WIDTH > 16) ? DOUT_WIDTH : 16;
    localparam int c_pw1  = (c_pw0 > c_xw) ? c_pw0 : c_xw;
    localparam int c_pw   = (c_pw1 > c_yw) ? c_pw1 : c_yw;

    localparam logic [c_xw-1:0] c_x_last  = c_xw'(FRAME_W - 1);
    localparam logic [c_yw-1:0] c_y_last  = c_yw'(FRAME_H - 1);
    localparam logic [c_bw-1:0] c_hb_last = c_bw'(HBLANK - 1);
    localparam logic [c_bw-1:0] c_vb_last = c_bw'(VBLANK - 1);
    localparam logic [15:0]     c_seed    = 16'hACE1;

`ifdef FILTER2D_SRC_CONT_EN
    localparam logic c_cont_en = 1'b1;
`else
    localparam logic c_cont_en = 1'b0;
`endif

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_active = 2'd1;
    localparam logic [1:0] c_st_hblank = 2'd2;
    localparam logic [1:0] c_st_vblank = 2'd3;

    logic [1:0]            r_state, w_state;
    logic [c_xw-1:0]       r_x, w_x;
    logic [c_yw-1:0]       r_y, w_y;
    logic [c_bw-1:0]       r_blank, w_blank;
    logic [15:0]           r_lfsr, w_lfsr;
    logic [1:0]            r_mode, w_mode;
    logic                  r_valid, w_valid;
    logic [DOUT_WIDTH-1:0] r_data, w_data;
    logic                  r_sof, w_sof;
    logic                  r_eol, w_eol;
    logic                  r_eof, w_eof;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  w_load;
    logic                  w_start_frame;

    // Fibonacci form, taps 16,14,13,11 map to bits 0,2,3,5 when shifting right
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [DOUT_WIDTH-1:0] pixel_value(
        input logic [1:0]      mode,
        input logic [c_xw-1:0] x,
        input logic [c_yw-1:0] y,
        input logic [15:0]     lfsr
    );
        logic [c_pw-1:0] v;
        case (mode)
            2'd0:    v = c_pw'(x);
            2'd1:    v = c_pw'(y);
            2'd2:    v = (x[0] ^ y[0]) ? '1 : '0;
            default: v = c_pw'(lfsr);
        endcase
        return v[DOUT_WIDTH-1:0];
    endfunction

    always_comb begin
        w_state       = r_state;
        w_x           = r_x;
        w_y           = r_y;
        w_blank       = r_blank;
        w_lfsr        = r_lfsr;
        w_mode        = r_mode;
        w_valid       = r_valid;
        w_data        = r_data;
        w_sof         = r_sof;
        w_eol         = r_eol;
        w_eof         = r_eof;
        w_done        = 1'b0;
        w_load        = 1'b0;
        w_start_frame = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (start_i) begin
                    w_start_frame = 1'b1;
                end
            end
            c_st_active: begin
                if (r_valid && m_ready_i) begin
                    w_lfsr = lfsr_step(r_lfsr);
                    if (r_x == c_x_last) begin
                        w_x = '0;
                        if (r_y == c_y_last) begin
                            w_y     = '0;
                            w_valid = 1'b0;
                            w_sof   = 1'b0;
                            w_eol   = 1'b0;
                            w_eof   = 1'b0;
                            w_blank = '0;
                            if (VBLANK > 0) begin
                                w_state = c_st_vblank;
                            end else begin
                                w_done = 1'b1;
                                if (c_cont_en && start_i) begin
                                    w_start_frame = 1'b1;
                                end else begin
                                    w_state = c_st_idle;
                                end
                            end
                        end else begin
                            w_y = r_y + c_yw'(1);
                            if (HBLANK > 0) begin
                                w_state = c_st_hblank;
                                w_blank = '0;
                                w_valid = 1'b0;
                                w_sof   = 1'b0;
                                w_eol   = 1'b0;
                                w_eof   = 1'b0;
                            end else begin
                                w_load = 1'b1;
                            end
                        end
                    end else begin
                        w_x    = r_x + c_xw'(1);
                        w_load = 1'b1;
                    end
                end
            end
            c_st_hblank: begin
                if (r_blank == c_hb_last) begin
                    w_state = c_st_active;
                    w_blank = '0;
                    w_load  = 1'b1;
                end else begin
                    w_blank = r_blank + c_bw'(1);
                end
            end
            default: begin
                if (r_blank == c_vb_last) begin
                    w_blank = '0;
                    w_done  = 1'b1;
                    if (c_cont_en && start_i) begin
                        w_start_frame = 1'b1;
                    end else begin
                        w_state = c_st_idle;
                    end
                end else begin
                    w_blank = r_blank + c_bw'(1);
                end
            end
        endcase

        // A new frame restarts the raster and reseeds the LFSR before the pixel is built
        if (w_start_frame) begin
            w_state = c_st_active;
            w_x     = '0;
            w_y     = '0;
            w_blank = '0;
            w_lfsr  = c_seed;
            w_mode  = mode_i;
            w_load  = 1'b1;
        end

        if (w_load) begin
            w_valid = 1'b1;
            w_data  = pixel_value(w_mode, w_x, w_y, w_lfsr);
            w_sof   = (w_x == '0) && (w_y == '0);
            w_eol   = (w_x == c_x_last);
            w_eof   = (w_x == c_x_last) && (w_y == c_y_last);
        end

        w_busy = (w_state != c_st_idle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_x     <= '0;
            r_y     <= '0;
            r_blank <= '0;
            r_lfsr  <= c_seed;
            r_mode  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_blank <= w_blank;
            r_lfsr  <= w_lfsr;
            r_mode  <= w_mode;
            r_valid <= w_valid;
            r_data  <= w_data;
            r_sof   <= w_sof;
            r_eol   <= w_eol;
            r_eof   <= w_eof;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign m_valid_o    = r_valid;
    assign m_data_o     = r_data;
    assign m_sof_o      = r_sof;
    assign m_eol_o      = r_eol;
    assign m_eof_o      = r_eof;
    assign busy_o       = r_busy;
    assign frame_done_o = r_done;

endmodule

`default_nettype wire

// File: tb/tb_filter2d_frame_src.sv
`default_nettype none
//==============================================================================
// Module   : tb_filter2d_frame_src
// Purpose  : Self-checking bench for filter2d_frame_src (4x3 frame, scoreboard).
// Revision : 1.0  initial release
//==============================================================================

module tb_filter2d_frame_src;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int DW = 8;
`ifdef FILTER2D_SRC_CONT_EN
    localparam int B2B_GAP = 4;
`else
    localparam int B2B_GAP = 5;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic          m_ready_i = 1'b0;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_sof_o, m_eol_o, m_eof_o, busy_o, frame_done_o;

    filter2d_frame_src #(
        .FRAME_W(W), .FRAME_H(H), .DOUT_WIDTH(DW), .HBLANK(HB), .VBLANK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_sof_o(m_sof_o), .m_eol_o(m_eol_o), .m_eof_o(m_eof_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] mode_mid;
        int         stall_pix;
        int         stall_len;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d4;
    } vec_t;

    pix_t    sbq[$];
    vec_t    vt[6];
    int      checks = 0;
    int      errors = 0;
    int      cyc_n = 0;
    int      frame_k = 0;
    int      eof_cyc = -100;
    int      done_cyc = -100;
    int      sof_rise_cyc = -100;
    int      eol_cyc = -100;
    int      done_cnt = 0;
    logic    eol_pending = 1'b0;
    logic    prev_valid = 1'b0;
    logic [DW-1:0] obs[0:31];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc_n);
        end
    endtask

    // Independent reference: LFSR state after n transfers from the seed
    function automatic logic [15:0] model_lfsr(input int n);
        logic [15:0] s;
        logic        fb;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            fb = s[0] ^ s[2] ^ s[3] ^ s[5];
            s  = {fb, s[15:1]};
        end
        return s;
    endfunction

    function automatic pix_t model_pix(input logic [1:0] mode, input int k);
        pix_t        p;
        int          x, y;
        logic [15:0] s;
        x = k % W;
        y = k / W;
        s = model_lfsr(k);
        case (mode)
            2'd0:    p.data = DW'(x);
            2'd1:    p.data = DW'(y);
            2'd2:    p.data = (((x ^ y) & 1) == 1) ? 8'hFF : 8'h00;
            default: p.data = s[7:0];
        endcase
        p.sof = (k == 0);
        p.eol = (x == W - 1);
        p.eof = (k == W * H - 1);
        return p;
    endfunction

    task automatic push_frame(input logic [1:0] mode);
        for (int k = 0; k < W * H; k++) sbq.push_back(model_pix(mode, k));
    endtask

    // Called at a negedge with inputs set for the coming posedge
    task automatic cyc();
        pix_t e;
        if (m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer got data %0h expected none (cycle %0d)", m_data_o, cyc_n);
            end else begin
                e = sbq.pop_front();
                chk("xfer_data", 32'(m_data_o), 32'(e.data));
                chk("xfer_flags", 32'({m_sof_o, m_eol_o, m_eof_o}), 32'({e.sof, e.eol, e.eof}));
                if (eol_pending) begin
                    chk("hblank_gap", cyc_n - eol_cyc, HB + 1);
                    eol_pending = 1'b0;
                end
                if (m_eol_o && !m_eof_o) begin
                    eol_pending = 1'b1;
                    eol_cyc     = cyc_n;
                end
                if (m_eof_o) eof_cyc = cyc_n;
                if (frame_k < 32) obs[frame_k] = m_data_o;
                frame_k++;
            end
        end
        if (m_valid_o === 1'b1 && m_sof_o === 1'b1 && prev_valid !== 1'b1) sof_rise_cyc = cyc_n;
        if (frame_done_o === 1'b1) begin
            done_cyc = cyc_n;
            done_cnt++;
        end
        prev_valid = m_valid_o;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v);
        int budget;
        int stall_left;
        int dc0;
        push_frame(v.mode);
        frame_k    = 0;
        eof_cyc    = -100;
        done_cyc   = -100;
        stall_left = v.stall_len;
        dc0        = done_cnt;
        start_i    = 1'b1;
        mode_i     = v.mode;
        m_ready_i  = 1'b1;
        cyc();
        start_i = 1'b0;
        chk("start_latency_valid", 32'(m_valid_o), 1);
        chk("busy_active", 32'(busy_o), 1);
        budget = 0;
        while (done_cyc < 0 && budget < 200) begin
            if (frame_k == v.stall_pix && stall_left > 0) begin
                m_ready_i = 1'b0;
                stall_left--;
                chk("stall_valid_held", 32'(m_valid_o), 1);
            end else begin
                m_ready_i = 1'b1;
            end
            if (frame_k >= 3) mode_i = v.mode_mid;
            cyc();
            budget++;
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout got no frame_done expected within 200 cycles");
        end
        chk("xfer_count", frame_k, W * H);
        chk("done_after_eof", done_cyc - eof_cyc, VB + 1);
        chk("done_pulses", done_cnt - dc0, 1);
        chk("busy_idle", 32'(busy_o), 0);
        chk("sb_empty", sbq.size(), 0);
        chk("tbl_d0", 32'(obs[0]), 32'(v.d0));
        chk("tbl_d1", 32'(obs[1]), 32'(v.d1));
        chk("tbl_d4", 32'(obs[4]), 32'(v.d4));
        for (int i = 0; i < 3; i++) cyc();
    endtask

    initial begin
        int budget;
        int e1, s2, d1;
        //            mode   mid    stall len  d0     d1     d4
        vt[0] = '{2'd0, 2'd0, -1, 0, 8'h00, 8'h01, 8'h00};
        vt[1] = '{2'd3, 2'd3,  2, 5, 8'hE1, 8'h70, 8'hCE};
        vt[2] = '{2'd3, 2'd3, -1, 0, 8'hE1, 8'h70, 8'hCE};
        vt[3] = '{2'd2, 2'd0, -1, 0, 8'h00, 8'hFF, 8'hFF};
        vt[4] = '{2'd0, 2'd0, -1, 0, 8'h00, 8'h01, 8'h00};
        vt[5] = '{2'd1, 2'd1,  5, 3, 8'h00, 8'h00, 8'h01};

        // Reset and idle
        @(negedge clk);
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_outputs", 32'({m_valid_o, m_data_o, m_sof_o, m_eol_o, m_eof_o, busy_o, frame_done_o}), 0);
        rst_n     = 1'b1;
        m_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_valid", 32'(m_valid_o), 0);
        end

        // Table of whole frames: ramp, stalled LFSR, free LFSR, checker w/ mode change, ramp, row
        for (int i = 0; i < 6; i++) run_frame(vt[i]);

        // Reset mid-frame at pixel 6
        push_frame(2'd0);
        frame_k   = 0;
        start_i   = 1'b1;
        mode_i    = 2'd0;
        m_ready_i = 1'b1;
        cyc();
        start_i = 1'b0;
        budget  = 0;
        while (frame_k < 6 && budget < 100) begin
            cyc();
            budget++;
        end
        chk("pix6_reached", frame_k, 6);
        m_ready_i = 1'b0;
        rst_n     = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midframe_rst_outputs", 32'({m_valid_o, m_data_o, m_sof_o, m_eol_o, m_eof_o, busy_o, frame_done_o}), 0);
        sbq.delete();
        eol_pending = 1'b0;
        m_ready_i   = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("post_rst_idle", 32'(m_valid_o), 0);
        run_frame(vt[0]);

        // start_i held high across two frames
        push_frame(2'd0);
        push_frame(2'd0);
        frame_k   = 0;
        eof_cyc   = -100;
        done_cyc  = -100;
        e1        = -1;
        s2        = -1;
        d1        = -1;
        start_i   = 1'b1;
        mode_i    = 2'd0;
        m_ready_i = 1'b1;
        budget    = 0;
        while (!(frame_k >= 2 * W * H && done_cyc > eof_cyc) && budget < 300) begin
            cyc();
            budget++;
            if (e1 < 0 && frame_k >= W * H) e1 = eof_cyc;
            if (e1 >= 0 && d1 < 0 && done_cyc > e1) d1 = done_cyc;
            if (e1 >= 0 && s2 < 0 && sof_rise_cyc > e1) begin
                s2      = sof_rise_cyc;
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        if (budget >= 300) begin
            checks++;
            errors++;
            $display("FAIL b2b_timeout got %0d transfers expected %0d", frame_k, 2 * W * H);
        end
        chk("b2b_second_sof_gap", s2 - e1, B2B_GAP);
        chk("b2b_first_done", d1 - e1, VB + 1);
        chk("b2b_xfers", frame_k, 2 * W * H);
        for (int i = 0; i < 5; i++) cyc();
        chk("b2b_stops", 32'({m_valid_o, busy_o}), 0);
        chk("b2b_sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
